// File: rtl/wisc_isa_pkg.sv
// WISC-S25 ISA constants shared by the instruction encoder: opcodes, field positions,
// and the loader FSM state encoding.
package wisc_isa_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Field positions inside the packed word
  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 8;
  localparam int COND_LSB = 9;
  localparam int RS_LSB   = 4;
  localparam int RT_LSB   = 0;

  localparam logic [INSTR_W-1:0] HLT_WORD = 16'hF000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded WISC-S25 fields -> 16-bit instruction word.
// With ENC_RANGE_CHECK_EN defined, range_ok flags immediates whose unused bits are illegal.
module instr_pack
  import wisc_isa_pkg::*;
(
  input  logic [3:0]         opcode,
  input  logic [3:0]         rd,
  input  logic [3:0]         rs,
  input  logic [3:0]         rt,
  input  logic [8:0]         imm,
  input  logic [2:0]         cond,
  output logic [INSTR_W-1:0] word,
  output logic               range_ok
);

  always_comb begin
    word = HLT_WORD;
    case (opcode)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: word = {opcode, rd, rs, rt};
      OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW:      word = {opcode, rd, rs, imm[3:0]};
      OP_LLB, OP_LHB:                            word = {opcode, rd, imm[7:0]};
      OP_B:                                      word = {opcode, cond, imm};
      OP_BR:                                     word = {opcode, cond, 1'b0, rs, 4'h0};
      OP_PCS:                                    word = {opcode, rd, 8'h00};
      default:                                   word = HLT_WORD;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // LW/SW offsets are signed 4-bit, so the upper bits must replicate imm[3]
  always_comb begin
    range_ok = 1'b1;
    case (opcode)
      OP_SLL, OP_SRA, OP_ROR: range_ok = (imm[8:4] == 5'b0);
      OP_LW, OP_SW:           range_ok = (imm[8:4] == {5{imm[3]}});
      OP_LLB, OP_LHB:         range_ok = ~imm[8];
      default:                range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder_writer.sv
// Program loader: packs decoded instructions and writes them to consecutive instruction
// memory words until HLT. Optional immediate range checking via ENC_RANGE_CHECK_EN.
module instr_encoder_writer
  import wisc_isa_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [8:0]        in_imm,
  input  logic [2:0]        in_cond,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       count
);

  state_t state, state_nxt;

  logic [INSTR_W-1:0] packed_word;
  logic               range_ok;
  logic               word_is_hlt;
  logic               start_load;
  logic               accept_fire;
  logic               write_fire;
  logic [ADDR_W:0]    addr_sum;

  instr_pack u_pack (
    .opcode   (in_opcode),
    .rd       (in_rd),
    .rs       (in_rs),
    .rt       (in_rt),
    .imm      (in_imm),
    .cond     (in_cond),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  assign start_load  = start && ((state == IDLE) || (state == DONE));
  assign accept_fire = in_valid && in_ready;
  assign write_fire  = mem_wr_en && mem_ack;
  // Extra top bit catches the carry out of the address, which marks a wrap
  assign addr_sum    = {1'b0, mem_addr} + (ADDR_W+1)'(ADDR_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_wr_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && range_ok) state_nxt = WRITE;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        busy      = 1'b1;
        if (mem_ack) state_nxt = word_is_hlt ? DONE : ACCEPT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ACCEPT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      count       <= '0;
      err         <= 1'b0;
      word_is_hlt <= 1'b0;
    end else begin
      if (start_load) begin
        mem_addr <= base_addr;
        count    <= '0;
        err      <= 1'b0;
      end
      if (accept_fire) begin
        if (range_ok) begin
          mem_wdata   <= packed_word;
          word_is_hlt <= (in_opcode == OP_HLT);
        end else begin
          err <= 1'b1;
        end
      end
      if (write_fire) begin
        mem_addr <= addr_sum[ADDR_W-1:0];
        if (addr_sum[ADDR_W]) err <= 1'b1;
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

endmodule
